// File: rtl/dac_serial_tx_pkg.sv
// Shared types and helpers for the serial DAC transmitter.
//   state_t    : FSM state encoding (2'd3 is unused and recovers to ST_IDLE)
//   clog2_min1 : ceiling log2, never smaller than 1, for counter/index widths
package dac_serial_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/dac_piso_shift.sv
// Parallel-load, serial-out shift register.
//   CLK1MHz, ResetN : clock, synchronous active-low reset
//   Load            : load Din (has priority over Shift)
//   Shift           : advance one bit, zero-filling behind
//   Din             : parallel word
//   Dout            : current serial bit, taken straight from a flop
module dac_piso_shift #(
    parameter int unsigned DATA_W    = 16,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              CLK1MHz,
    input  logic              ResetN,
    input  logic              Load,
    input  logic              Shift,
    input  logic [DATA_W-1:0] Din,
    output logic              Dout
);

    logic [DATA_W-1:0] r_sh;
    logic [DATA_W-1:0] w_shifted;

    // Zero fill means that after DATA_W shifts the output bit reads 0.
    generate
        if (MSB_FIRST) begin : g_msb
            assign w_shifted = {r_sh[DATA_W-2:0], 1'b0};
            assign Dout      = r_sh[DATA_W-1];
        end else begin : g_lsb
            assign w_shifted = {1'b0, r_sh[DATA_W-1:1]};
            assign Dout      = r_sh[0];
        end
    endgenerate

    always_ff @(posedge CLK1MHz) begin
        if (!ResetN)    r_sh <= '0;
        else if (Load)  r_sh <= Din;
        else if (Shift) r_sh <= w_shifted;
    end

endmodule

// File: rtl/dac_serial_tx.sv
// Multi-channel serial DAC transmitter: on Start, captures NUM_CH words and
// sends each as one Sync-low frame followed by GAP_CYCLES Sync-high cycles.
//   CLK1MHz, ResetN : clock, synchronous active-low reset
//   Start           : transaction request, sampled only while idle
//   DinParalelo     : channel c at bits [c*DATA_W +: DATA_W]
//   Busy, Done      : in-progress flag, one-cycle end pulse
//   ChIdx           : channel being framed (0 when idle)
//   Sync            : active-low frame strobe
//   DoutSerial      : serial data
module dac_serial_tx
    import dac_serial_tx_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned GAP_CYCLES = 1,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic                             CLK1MHz,
    input  logic                             ResetN,
    input  logic                             Start,
    input  logic [NUM_CH*DATA_W-1:0]         DinParalelo,
    output logic                             Busy,
    output logic                             Done,
    output logic [clog2_min1(NUM_CH)-1:0]    ChIdx,
    output logic                             Sync,
    output logic                             DoutSerial
);

    localparam int unsigned CH_W  = clog2_min1(NUM_CH);
    localparam int unsigned BIT_W = clog2_min1(DATA_W);
    localparam int unsigned GAP_W = 4;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

    state_t            r_state, w_state_nxt;
    logic [BIT_W-1:0]  r_bit,   w_bit_nxt;
    logic [GAP_W-1:0]  r_gap,   w_gap_nxt;
    logic [CH_W-1:0]   r_ch,    w_ch_nxt;
    logic              r_sync,  w_sync_nxt;
    logic              r_busy,  w_busy_nxt;
    logic              r_done,  w_done_nxt;
    logic [DATA_W-1:0] r_hold [NUM_CH];

    logic              w_capture;
    logic              w_load;
    logic              w_shift;
    logic [DATA_W-1:0] w_din;
    logic [CH_W-1:0]   w_ch_inc;

    // Clamped so the holding-register index never leaves the array.
    assign w_ch_inc = (r_ch == CH_LAST) ? r_ch : r_ch + 1'b1;

    // Next state, counters and output values.
    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit;
        w_gap_nxt   = r_gap;
        w_ch_nxt    = r_ch;
        w_sync_nxt  = 1'b1;
        w_busy_nxt  = 1'b1;
        w_done_nxt  = 1'b0;
        w_capture   = 1'b0;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_din       = '0;

        case (r_state)
            ST_IDLE: begin
                // Loading zeros while idle keeps DoutSerial at 0.
                w_ch_nxt   = '0;
                w_busy_nxt = 1'b0;
                w_load     = 1'b1;
                if (Start) begin
                    // Channel 0 comes from the port: the hold register fills on this same edge.
                    w_capture   = 1'b1;
                    w_din       = DinParalelo[DATA_W-1:0];
                    w_bit_nxt   = '0;
                    w_sync_nxt  = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // The shift after the last bit empties the register, so DoutSerial reads 0 in GAP.
                w_shift = 1'b1;
                if (r_bit == BIT_LAST) begin
                    w_gap_nxt   = '0;
                    w_state_nxt = ST_GAP;
                end else begin
                    w_bit_nxt  = r_bit + 1'b1;
                    w_sync_nxt = 1'b0;
                end
            end
            ST_GAP: begin
                if (r_gap == GAP_LAST) begin
                    if (r_ch != CH_LAST) begin
                        w_ch_nxt    = w_ch_inc;
                        w_din       = r_hold[w_ch_inc];
                        w_load      = 1'b1;
                        w_bit_nxt   = '0;
                        w_sync_nxt  = 1'b0;
                        w_state_nxt = ST_SHIFT;
                    end else begin
                        w_ch_nxt    = '0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_gap_nxt = r_gap + 1'b1;
                end
            end
            default: begin
                w_ch_nxt    = '0;
                w_busy_nxt  = 1'b0;
                w_load      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK1MHz) begin
        if (!ResetN) begin
            r_state <= ST_IDLE;
            r_bit   <= '0;
            r_gap   <= '0;
            r_ch    <= '0;
            r_sync  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_bit   <= w_bit_nxt;
            r_gap   <= w_gap_nxt;
            r_ch    <= w_ch_nxt;
            r_sync  <= w_sync_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Holding register isolates the transaction from later DinParalelo changes.
    always_ff @(posedge CLK1MHz) begin
        if (w_capture) begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                r_hold[c] <= DinParalelo[c*DATA_W +: DATA_W];
            end
        end
    end

    dac_piso_shift #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_piso (
        .CLK1MHz (CLK1MHz),
        .ResetN  (ResetN),
        .Load    (w_load),
        .Shift   (w_shift),
        .Din     (w_din),
        .Dout    (DoutSerial)
    );

    assign Sync  = r_sync;
    assign Busy  = r_busy;
    assign Done  = r_done;
    assign ChIdx = r_ch;

endmodule

// File: tb/tb_dac_serial_tx.sv
// Bench for dac_serial_tx: three configurations checked every cycle against
// a per-cycle model derived from the frame layout, plus literal checks.
module tb_dac_serial_tx;
    import dac_serial_tx_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cycle);
        end
    endtask

    // Expected {Busy, Done, Sync, DoutSerial, ChIdx[3:0]} at cycle k after the Start edge.
    function automatic logic [7:0] model_out(input int k, input logic [255:0] cap,
                                             input int d, input int n, input int g, input int msb);
        int total;
        int ch;
        int r;
        logic b;
        total = n * (d + g);
        if (k < 0 || k > total) return 8'h20;
        if (k == total) return 8'h60;
        ch = k / (d + g);
        r  = k % (d + g);
        if (r >= d) return {4'hA, 4'(ch)};
        b = (msb != 0) ? cap[ch*d + d - 1 - r] : cap[ch*d + r];
        return {3'b100, b, 4'(ch)};
    endfunction

    // Instance A: 16 bit, 2 channels, gap 1, MSB first.
    logic a_rst_n = 1'b0, a_start = 1'b0;
    logic [31:0] a_din = '0;
    logic a_busy, a_done, a_sync, a_dout;
    logic [0:0] a_ch;
    dac_serial_tx #(.DATA_W(16), .NUM_CH(2), .GAP_CYCLES(1), .MSB_FIRST(1'b1)) u_a (
        .CLK1MHz(clk), .ResetN(a_rst_n), .Start(a_start), .DinParalelo(a_din),
        .Busy(a_busy), .Done(a_done), .ChIdx(a_ch), .Sync(a_sync), .DoutSerial(a_dout));

    // Instance B: 12 bit, 1 channel, gap 1, LSB first.
    logic b_rst_n = 1'b0, b_start = 1'b0;
    logic [11:0] b_din = '0;
    logic b_busy, b_done, b_sync, b_dout;
    logic [0:0] b_ch;
    dac_serial_tx #(.DATA_W(12), .NUM_CH(1), .GAP_CYCLES(1), .MSB_FIRST(1'b0)) u_b (
        .CLK1MHz(clk), .ResetN(b_rst_n), .Start(b_start), .DinParalelo(b_din),
        .Busy(b_busy), .Done(b_done), .ChIdx(b_ch), .Sync(b_sync), .DoutSerial(b_dout));

    // Instance C: 16 bit, 3 channels, gap 3, MSB first.
    logic c_rst_n = 1'b0, c_start = 1'b0;
    logic [47:0] c_din = '0;
    logic c_busy, c_done, c_sync, c_dout;
    logic [1:0] c_ch;
    dac_serial_tx #(.DATA_W(16), .NUM_CH(3), .GAP_CYCLES(3), .MSB_FIRST(1'b1)) u_c (
        .CLK1MHz(clk), .ResetN(c_rst_n), .Start(c_start), .DinParalelo(c_din),
        .Busy(c_busy), .Done(c_done), .ChIdx(c_ch), .Sync(c_sync), .DoutSerial(c_dout));

    // Per-instance model trackers: k = cycles since the accepted Start edge, -1 when idle.
    logic a_chk_en = 1'b1;
    int ka = -1, kb = -1, kc = -1;
    logic [255:0] cap_a = '0, cap_b = '0, cap_c = '0;

    initial forever begin
        @(posedge clk);
        if (!a_rst_n) ka = -1;
        else if ((ka < 0 || ka == 34) && a_start) begin ka = 0; cap_a = 256'(a_din); end
        else if (ka >= 0) begin ka++; if (ka > 34) ka = -1; end
        #1;
        if (a_chk_en)
            check("a_out", {24'b0, a_busy, a_done, a_sync, a_dout, 3'b0, a_ch},
                  32'(model_out(ka, cap_a, 16, 2, 1, 1)));
    end

    initial forever begin
        @(posedge clk);
        if (!b_rst_n) kb = -1;
        else if ((kb < 0 || kb == 13) && b_start) begin kb = 0; cap_b = 256'(b_din); end
        else if (kb >= 0) begin kb++; if (kb > 13) kb = -1; end
        #1;
        check("b_out", {24'b0, b_busy, b_done, b_sync, b_dout, 3'b0, b_ch},
              32'(model_out(kb, cap_b, 12, 1, 1, 0)));
    end

    initial forever begin
        @(posedge clk);
        if (!c_rst_n) kc = -1;
        else if ((kc < 0 || kc == 57) && c_start) begin kc = 0; cap_c = 256'(c_din); end
        else if (kc >= 0) begin kc++; if (kc > 57) kc = -1; end
        #1;
        check("c_out", {24'b0, c_busy, c_done, c_sync, c_dout, 2'b0, c_ch},
              32'(model_out(kc, cap_c, 16, 3, 3, 1)));
    end

    task automatic wait_a_idle(input string name);
        int w;
        w = 0;
        while ((a_busy || a_done) && w < 200) begin @(negedge clk); w++; end
        check(name, 32'(a_busy), 32'd0);
    endtask

    logic s_arr [40];
    logic d_arr [40];
    logic bz_arr [40];
    logic dn_arr [40];

    initial begin
        int busy_cnt, done_cnt, low_cnt;
        logic [15:0] w0, w1;
        logic [11:0] wb;
        int done_t [$];

        repeat (3) @(negedge clk);
        check("rst_a", {27'b0, a_busy, a_done, a_sync, a_dout, a_ch}, 32'b00100);
        check("rst_c", {26'b0, c_busy, c_done, c_sync, c_dout, c_ch}, 32'b001000);

        // Literal pins on the model itself.
        check("mdl_a_k0",  32'(model_out(0,  256'h0FF0A5C3, 16, 2, 1, 1)), 32'h90);
        check("mdl_a_k1",  32'(model_out(1,  256'h0FF0A5C3, 16, 2, 1, 1)), 32'h80);
        check("mdl_a_k16", 32'(model_out(16, 256'h0FF0A5C3, 16, 2, 1, 1)), 32'hA0);
        check("mdl_a_k17", 32'(model_out(17, 256'h0FF0A5C3, 16, 2, 1, 1)), 32'h81);
        check("mdl_a_k21", 32'(model_out(21, 256'h0FF0A5C3, 16, 2, 1, 1)), 32'h91);
        check("mdl_a_k34", 32'(model_out(34, 256'h0FF0A5C3, 16, 2, 1, 1)), 32'h60);
        check("mdl_b_k11", 32'(model_out(11, 256'h801, 12, 1, 1, 0)), 32'h90);
        check("mdl_b_k5",  32'(model_out(5,  256'h801, 12, 1, 1, 0)), 32'h80);

        a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed transaction on A.
        a_din = 32'h0FF0A5C3; a_start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            s_arr[i] = a_sync; d_arr[i] = a_dout; bz_arr[i] = a_busy; dn_arr[i] = a_done;
            a_start = 1'b0;
        end
        busy_cnt = 0; done_cnt = 0; w0 = '0; w1 = '0;
        for (int i = 0; i < 40; i++) begin
            busy_cnt += int'(bz_arr[i]);
            done_cnt += int'(dn_arr[i]);
        end
        for (int i = 0; i < 16; i++) begin
            w0 = {w0[14:0], d_arr[i]};
            w1 = {w1[14:0], d_arr[17+i]};
        end
        check("a_word0", 32'(w0), 32'hA5C3);
        check("a_word1", 32'(w1), 32'h0FF0);
        check("a_gap",   {29'b0, s_arr[15], s_arr[16], s_arr[17]}, 32'b010);
        check("a_busy_cnt", 32'(busy_cnt), 32'd34);
        check("a_done_cnt", 32'(done_cnt), 32'd1);
        check("a_done_pos", {30'b0, dn_arr[34], bz_arr[34]}, 32'b10);

        // Random transactions: data churn after capture and Start during Busy.
        for (int t = 0; t < 8; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            a_din = $urandom; a_start = 1'b1;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                a_din = $urandom;
                a_start = 1'($urandom_range(0, 1));
            end
            a_start = 1'b0;
            wait_a_idle("a_rand_idle");
        end

        // Abort at bit 7 of channel 1.
        @(negedge clk);
        a_din = 32'h1234ABCD; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (24) @(negedge clk);
        a_rst_n = 1'b0;
        @(negedge clk);
        a_rst_n = 1'b1;
        check("a_abort", {27'b0, a_busy, a_done, a_sync, a_dout, a_ch}, 32'b00100);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin @(negedge clk); done_cnt += int'(a_done); end
        check("a_abort_nodone", 32'(done_cnt), 32'd0);
        a_din = 32'hC0DE5AA5; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (3) @(negedge clk);
        wait_a_idle("a_after_abort");

        // Illegal state recovery.
        a_din = 32'hFFFFFFFF; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (5) @(negedge clk);
        a_chk_en = 1'b0;
        force u_a.r_state = state_t'(2'd3);
        @(negedge clk);
        check("a_illegal_sync", {30'b0, a_sync, a_busy}, 32'b10);
        release u_a.r_state;
        @(negedge clk);
        check("a_illegal_idle", {29'b0, a_sync, a_busy, a_dout}, 32'b100);
        a_rst_n = 1'b0;
        @(negedge clk);
        a_rst_n = 1'b1;
        a_chk_en = 1'b1;
        repeat (2) @(negedge clk);

        // LSB-first single channel on B.
        b_din = 12'h801; b_start = 1'b1;
        wb = '0; low_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            b_start = 1'b0;
            if (i < 12) wb[i] = b_dout;
            low_cnt += int'(!b_sync);
        end
        check("b_word", 32'(wb), 32'h801);
        check("b_sync_low", 32'(low_cnt), 32'd12);
        for (int t = 0; t < 4; t++) begin
            b_din = 12'($urandom); b_start = 1'b1;
            @(negedge clk);
            b_start = 1'b0;
            repeat (16) @(negedge clk);
        end

        // Start held high on C: Done pulses must be 58 cycles apart.
        c_start = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            c_din = {$urandom, 16'($urandom)};
            if (c_done) done_t.push_back(cycle);
        end
        c_start = 1'b0;
        check("c_done_count", 32'(done_t.size() >= 3), 32'd1);
        for (int i = 1; i < done_t.size(); i++)
            check("c_done_period", 32'(done_t[i] - done_t[i-1]), 32'd58);
        repeat (70) @(negedge clk);
        check("c_idle", {30'b0, c_busy, c_sync}, 32'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
